alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DATA_SIZE, 8, width of operands A, B and of the result.
REQ-002 Parameter OPCODE_SIZE, 6, opcode width; SHALL be no greater than 8.
REQ-003 Parameter TIMEOUT_CYCLES, 4000, maximum clocks allowed between bytes of one command.
REQ-004 Port i_clock, in, 1, single clock; all logic is rising-edge.
REQ-005 Port i_reset, in, 1, asynchronous, active-high reset.
REQ-006 Port i_rx_data, in, 8, received byte; valid only while i_rx_done is high.
REQ-007 Port i_rx_done, in, 1, one-cycle pulse marking a new received byte.
REQ-008 Port i_alu_result, in, DATA_SIZE, combinational ALU output for o_a/o_b/o_op.
REQ-009 Port i_tx_done, in, 1, one-cycle pulse; the transmitter has finished its byte.
REQ-010 Port o_a, out, DATA_SIZE, registered operand A.
REQ-011 Port o_b, out, DATA_SIZE, registered operand B.
REQ-012 Port o_op, out, OPCODE_SIZE, registered opcode.
REQ-013 Port o_tx_data, out, DATA_SIZE, registered result byte for the transmitter.
REQ-014 Port o_tx_start, out, 1, one-cycle pulse requesting transmission of o_tx_data.
REQ-015 Port o_busy, out, 1, high in every state except GET_A.
REQ-016 Port o_timeout, out, 1, one-cycle pulse when a partial command is abandoned.
REQ-017 Port o_overrun, out, 1, one-cycle pulse when a received byte is dropped.

Function
REQ-018 The FSM SHALL have states GET_A, GET_B, GET_OP, EXEC, SEND and WAIT_TX.
REQ-019 In GET_A, an i_rx_done pulse SHALL load o_a with i_rx_data[DATA_SIZE-1:0] and move to GET_B.
REQ-020 In GET_B, i_rx_done SHALL load o_b and move to GET_OP.
REQ-021 In GET_OP, i_rx_done SHALL load o_op with i_rx_data[OPCODE_SIZE-1:0] (upper bits ignored) and move to EXEC.
REQ-022 EXEC SHALL last exactly one cycle, capture i_alu_result into o_tx_data at its end and move to SEND.
REQ-023 SEND SHALL last one cycle with o_tx_start high and then move to WAIT_TX; o_tx_start SHALL be low in every other state.
REQ-024 WAIT_TX SHALL return to GET_A on i_tx_done; i_tx_done SHALL be ignored in all other states.
REQ-025 Latency: with the opcode byte's i_rx_done in cycle T, o_tx_start SHALL be high in cycle T+2.
REQ-026 o_a, o_b, o_op and o_tx_data SHALL hold their values until reloaded.
REQ-027 An idle counter SHALL clear on entry to GET_B or GET_OP and increment every cycle in those states.
REQ-028 When the idle counter reaches TIMEOUT_CYCLES-1 without i_rx_done, the FSM SHALL go to GET_A and pulse o_timeout; operands SHALL keep their values.
REQ-029 If i_rx_done and timeout expiry coincide, the byte SHALL win: it is accepted and no timeout is raised.
REQ-030 i_rx_done in EXEC, SEND or WAIT_TX SHALL drop the byte and pulse o_overrun the next cycle; the FSM SHALL not change state.
REQ-031 If i_rx_done and i_tx_done coincide in WAIT_TX, the FSM SHALL return to GET_A, the byte SHALL be dropped and o_overrun SHALL pulse.
REQ-032 The idle counter SHALL be ceil(log2(TIMEOUT_CYCLES)) bits wide and SHALL not wrap.

Reset
REQ-033 i_reset SHALL asynchronously force state GET_A and clear the idle counter, o_a, o_b, o_op and o_tx_data to 0.
REQ-034 During reset, o_tx_start, o_timeout and o_overrun SHALL be 0, and so SHALL o_busy.
REQ-035 Reset asserted mid-command or during WAIT_TX SHALL abandon the command with no o_tx_start and no o_timeout.

Structure
REQ-036 The state encoding and default parameter values SHALL live in a shared sequencer constants package used by the UART top.
REQ-037 The idle counter SHALL be a sub-module named seq_timeout_counter (inputs clear and enable, output expired); everything else stays flat.

Verification
REQ-038 Bytes 0x05, 0x03, 0x20 with a model returning 0x08 -> o_a=0x05, o_b=0x03, o_op=0x20, o_tx_data=0x08, one o_tx_start pulse 2 cycles after the third byte.
REQ-039 Bytes 0xFF, 0x01, 0xE2 -> o_op=0x22 (upper bits dropped); o_busy stays high until i_tx_done.
REQ-040 Byte 0x11 followed by TIMEOUT_CYCLES idle clocks -> one o_timeout pulse, FSM in GET_A, o_busy=0, no o_tx_start.
REQ-041 Byte 0x22 during WAIT_TX -> o_overrun pulse, state unchanged; after i_tx_done the next three bytes form a correct new command.
REQ-042 i_reset asserted in GET_OP, then released -> all outputs 0 and no o_tx_start; a following full command completes normally.
REQ-043 Second byte's i_rx_done in the exact timeout cycle -> the byte is accepted, no o_timeout, FSM in GET_OP.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared constants for the ALU command sequencer: the default parameter
// values, the width of a received byte, the FSM state encoding and a small
// helper that says whether the FSM is collecting command bytes.
package alu_cmd_sequencer_pkg;

  localparam int SEQ_DATA_SIZE      = 8;
  localparam int SEQ_OPCODE_SIZE    = 6;
  localparam int SEQ_TIMEOUT_CYCLES = 4000;
  localparam int SEQ_RX_WIDTH       = 8;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } seq_state_e;

  // GET_B and GET_OP are the only states in which the idle counter runs.
  function automatic logic is_collecting(input seq_state_e s);
    return (s == GET_B) || (s == GET_OP);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the byte-receive, ALU and transmit handshake signals of the
// ALU command sequencer.
//   slave  : the sequencer side (receives i_* and drives o_*)
//   master : the environment side (UART rx/tx, ALU)
// Signals:
//   i_rx_data/i_rx_done : received byte and its one-cycle strobe
//   i_alu_result        : combinational ALU result for o_a/o_b/o_op
//   i_tx_done           : transmitter finished its byte
//   o_a/o_b/o_op        : registered operands and opcode
//   o_tx_data/o_tx_start: result byte and its one-cycle send request
//   o_busy/o_timeout/o_overrun : status outputs
interface alu_cmd_sequencer_if
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DATA_SIZE   = SEQ_DATA_SIZE,
  parameter int OPCODE_SIZE = SEQ_OPCODE_SIZE
);

  logic [SEQ_RX_WIDTH-1:0] i_rx_data;
  logic                    i_rx_done;
  logic [DATA_SIZE-1:0]    i_alu_result;
  logic                    i_tx_done;
  logic [DATA_SIZE-1:0]    o_a;
  logic [DATA_SIZE-1:0]    o_b;
  logic [OPCODE_SIZE-1:0]  o_op;
  logic [DATA_SIZE-1:0]    o_tx_data;
  logic                    o_tx_start;
  logic                    o_busy;
  logic                    o_timeout;
  logic                    o_overrun;

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_a, o_b, o_op, o_tx_data, o_tx_start, o_busy, o_timeout, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_a, o_b, o_op, o_tx_data, o_tx_start, o_busy, o_timeout, o_overrun
  );

endinterface

// File: rtl/alu_cmd_sequencer_timeout_counter.sv
// Idle counter for the ALU command sequencer (module seq_timeout_counter).
// Ports:
//   clk_i, rst_i : rising-edge clock, asynchronous active-high reset
//   clear_i      : restart the count from zero (has priority over enable)
//   enable_i     : count one cycle
//   expired_o    : the count has reached TIMEOUT_CYCLES-1
// The counter saturates at TIMEOUT_CYCLES-1 instead of wrapping, so an
// expired count stays expired until it is cleared.
module seq_timeout_counter
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stop at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: collects operand A, operand B and an opcode as
// three received bytes, lets the external ALU compute for one cycle,
// latches the result and asks the transmitter to send it, then waits for
// the transmitter to finish before accepting the next command.
// Ports:
//   i_clock : rising-edge clock
//   i_reset : asynchronous active-high reset
//   bus     : alu_cmd_sequencer_if.slave (rx byte, ALU, tx handshake and
//             status outputs)
// A partial command stalls for at most TIMEOUT_CYCLES cycles per byte
// before it is abandoned with an o_timeout pulse. Bytes arriving while a
// result is computed or sent are dropped and flagged with o_overrun.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DATA_SIZE      = SEQ_DATA_SIZE,
  parameter int OPCODE_SIZE    = SEQ_OPCODE_SIZE,
  parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_CYCLES
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  alu_cmd_sequencer_if.slave   bus
);

  seq_state_e             state_q;
  logic [DATA_SIZE-1:0]   a_q;
  logic [DATA_SIZE-1:0]   b_q;
  logic [OPCODE_SIZE-1:0] op_q;
  logic [DATA_SIZE-1:0]   tx_data_q;
  logic                   tx_start_q;
  logic                   busy_q;
  logic                   timeout_q;
  logic                   overrun_q;

  logic                   cnt_clear_s;
  logic                   cnt_enable_s;
  logic                   expired_s;

  // The counter restarts on every accepted byte that leads into GET_B or
  // GET_OP, so each byte gets its own full timeout window.
  assign cnt_clear_s  = bus.i_rx_done && ((state_q == GET_A) || (state_q == GET_B));
  assign cnt_enable_s = is_collecting(state_q);

  seq_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (i_clock),
    .rst_i     (i_reset),
    .clear_i   (cnt_clear_s),
    .enable_i  (cnt_enable_s),
    .expired_o (expired_s)
  );

  // Command FSM with registered operands, result and status pulses.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= GET_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      case (state_q)
        GET_A: begin
          if (bus.i_rx_done) begin
            a_q     <= bus.i_rx_data[DATA_SIZE-1:0];
            state_q <= GET_B;
            busy_q  <= 1'b1;
          end
        end
        GET_B: begin
          // A byte in the expiry cycle is still accepted.
          if (bus.i_rx_done) begin
            b_q     <= bus.i_rx_data[DATA_SIZE-1:0];
            state_q <= GET_OP;
          end else if (expired_s) begin
            state_q   <= GET_A;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        GET_OP: begin
          if (bus.i_rx_done) begin
            op_q    <= bus.i_rx_data[OPCODE_SIZE-1:0];
            state_q <= EXEC;
          end else if (expired_s) begin
            state_q   <= GET_A;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        EXEC: begin
          // Operands have been stable for this whole cycle.
          tx_data_q  <= bus.i_alu_result;
          tx_start_q <= 1'b1;
          overrun_q  <= bus.i_rx_done;
          state_q    <= SEND;
        end
        SEND: begin
          overrun_q <= bus.i_rx_done;
          state_q   <= WAIT_TX;
        end
        WAIT_TX: begin
          overrun_q <= bus.i_rx_done;
          if (bus.i_tx_done) begin
            state_q <= GET_A;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= GET_A;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_a        = a_q;
  assign bus.o_b        = b_q;
  assign bus.o_op       = op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_overrun  = overrun_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized bench for alu_cmd_sequencer. Inputs are driven on
// the falling edge and outputs are sampled on the falling edge.
module tb_alu_cmd_sequencer;

  localparam int TO = 4000;

  logic clk;
  logic rst;

  alu_cmd_sequencer_if #(.DATA_SIZE(8), .OPCODE_SIZE(6)) bus_if ();

  alu_cmd_sequencer #(
    .DATA_SIZE      (8),
    .OPCODE_SIZE    (6),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: operation selected by the two low opcode bits.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign bus_if.i_alu_result = alu_model(bus_if.o_a, bus_if.o_b, bus_if.o_op);

  int n_assert = 0;
  int n_fail   = 0;

  // Observed pulse counts (a pulse present in a cycle is counted at its closing edge).
  int obs_start = 0;
  int obs_to    = 0;
  int obs_ovr   = 0;
  always @(posedge clk) begin
    if (bus_if.o_tx_start === 1'b1) obs_start++;
    if (bus_if.o_timeout  === 1'b1) obs_to++;
    if (bus_if.o_overrun  === 1'b1) obs_ovr++;
  end

  // Reference model state.
  logic [7:0] exp_a, exp_b, exp_tx;
  logic [5:0] exp_op;
  int exp_start = 0;
  int exp_to    = 0;
  int exp_ovr   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus_if.i_rx_data = b;
    bus_if.i_rx_done = 1'b1;
    @(negedge clk);
    bus_if.i_rx_done = 1'b0;
    bus_if.i_rx_data = 8'($urandom);
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    bus_if.i_tx_done = 1'b1;
    @(negedge clk);
    bus_if.i_tx_done = 1'b0;
  endtask

  // Called right after the opcode byte was taken (FSM now computing).
  // mode 0: normal; 1: stray byte in WAIT_TX; 2: stray byte together with i_tx_done.
  task automatic finish_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input int wt, input int mode);
    exp_a  = a;
    exp_b  = b;
    exp_op = op[5:0];
    exp_tx = alu_model(a, b, op[5:0]);
    chk("exec_no_start", 32'(bus_if.o_tx_start), 32'd0);
    chk("op_loaded", 32'(bus_if.o_op), 32'(exp_op));
    chk("a_held", 32'(bus_if.o_a), 32'(exp_a));
    chk("b_held", 32'(bus_if.o_b), 32'(exp_b));
    @(negedge clk);
    chk("start_t_plus_2", 32'(bus_if.o_tx_start), 32'd1);
    chk("tx_data", 32'(bus_if.o_tx_data), 32'(exp_tx));
    exp_start++;
    @(negedge clk);
    chk("start_one_cycle", 32'(bus_if.o_tx_start), 32'd0);
    chk("busy_wait_tx", 32'(bus_if.o_busy), 32'd1);
    if (mode == 1) begin
      send_byte(8'($urandom));
      exp_ovr++;
      chk("ovr_pulse", 32'(bus_if.o_overrun), 32'd1);
      chk("ovr_busy", 32'(bus_if.o_busy), 32'd1);
      chk("ovr_a_kept", 32'(bus_if.o_a), 32'(exp_a));
      @(negedge clk);
      chk("ovr_one_cycle", 32'(bus_if.o_overrun), 32'd0);
    end
    idle(wt);
    chk("busy_before_txdone", 32'(bus_if.o_busy), 32'd1);
    if (mode == 2) begin
      @(negedge clk);
      bus_if.i_rx_data = 8'($urandom);
      bus_if.i_rx_done = 1'b1;
      bus_if.i_tx_done = 1'b1;
      @(negedge clk);
      bus_if.i_rx_done = 1'b0;
      bus_if.i_tx_done = 1'b0;
      exp_ovr++;
      chk("coinc_ovr", 32'(bus_if.o_overrun), 32'd1);
      chk("coinc_a_kept", 32'(bus_if.o_a), 32'(exp_a));
    end else begin
      pulse_tx_done();
    end
    chk("idle_after_tx", 32'(bus_if.o_busy), 32'd0);
    chk("tx_data_held", 32'(bus_if.o_tx_data), 32'(exp_tx));
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int gap, input int wt, input int mode);
    send_byte(a);
    chk("a_loaded", 32'(bus_if.o_a), 32'(a));
    chk("busy_get_b", 32'(bus_if.o_busy), 32'd1);
    idle(gap);
    send_byte(b);
    chk("b_loaded", 32'(bus_if.o_b), 32'(b));
    idle(gap);
    send_byte(op);
    finish_cmd(a, b, op, wt, mode);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"},     32'(bus_if.o_a), 32'd0);
    chk({tag, "_b"},     32'(bus_if.o_b), 32'd0);
    chk({tag, "_op"},    32'(bus_if.o_op), 32'd0);
    chk({tag, "_tx"},    32'(bus_if.o_tx_data), 32'd0);
    chk({tag, "_start"}, 32'(bus_if.o_tx_start), 32'd0);
    chk({tag, "_busy"},  32'(bus_if.o_busy), 32'd0);
    chk({tag, "_to"},    32'(bus_if.o_timeout), 32'd0);
    chk({tag, "_ovr"},   32'(bus_if.o_overrun), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus_if.i_rx_data = 8'h00;
    bus_if.i_rx_done = 1'b0;
    bus_if.i_tx_done = 1'b0;
    #1 rst = 1'b1;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);
    chk_all_zero("post_reset");

    // Basic command: 5 + 3.
    run_cmd(8'h05, 8'h03, 8'h20, 0, 3, 0);
    chk("req038_a", 32'(bus_if.o_a), 32'h05);
    chk("req038_b", 32'(bus_if.o_b), 32'h03);
    chk("req038_op", 32'(bus_if.o_op), 32'h20);
    chk("req038_tx", 32'(bus_if.o_tx_data), 32'h08);

    // Upper opcode bits dropped; long wait for the transmitter.
    run_cmd(8'hFF, 8'h01, 8'hE2, 2, 20, 0);
    chk("req039_op", 32'(bus_if.o_op), 32'h22);

    // i_tx_done outside WAIT_TX is ignored.
    send_byte(8'h40);
    pulse_tx_done();
    chk("txdone_ignored", 32'(bus_if.o_busy), 32'd1);
    send_byte(8'h02);
    send_byte(8'h03);
    finish_cmd(8'h40, 8'h02, 8'h03, 1, 0);

    // Timeout after the first byte.
    send_byte(8'h11);
    idle(TO - 1);
    chk("to_not_early", 32'(bus_if.o_timeout), 32'd0);
    chk("to_busy_last", 32'(bus_if.o_busy), 32'd1);
    idle(1);
    exp_to++;
    chk("to_pulse", 32'(bus_if.o_timeout), 32'd1);
    chk("to_busy", 32'(bus_if.o_busy), 32'd0);
    chk("to_a_kept", 32'(bus_if.o_a), 32'h11);
    chk("to_b_kept", 32'(bus_if.o_b), 32'(exp_b));
    idle(1);
    chk("to_one_cycle", 32'(bus_if.o_timeout), 32'd0);
    chk("to_no_start", 32'(obs_start), 32'(exp_start));

    // Second byte lands in the expiry cycle: byte wins.
    send_byte(8'h33);
    idle(TO - 2);
    send_byte(8'h44);
    chk("edge_b", 32'(bus_if.o_b), 32'h44);
    chk("edge_no_to", 32'(bus_if.o_timeout), 32'd0);
    chk("edge_busy", 32'(bus_if.o_busy), 32'd1);
    idle(1);
    chk("edge_no_to_late", 32'(bus_if.o_timeout), 32'd0);
    send_byte(8'h03);
    finish_cmd(8'h33, 8'h44, 8'h03, 0, 0);

    // Stray byte in WAIT_TX, then a clean command.
    run_cmd(8'h12, 8'h34, 8'h01, 0, 2, 1);
    run_cmd(8'h9A, 8'h0F, 8'h02, 1, 0, 0);
    // Stray byte coinciding with i_tx_done.
    run_cmd(8'h70, 8'h07, 8'h03, 0, 1, 2);

    // Reset in GET_OP abandons the command.
    send_byte(8'h55);
    send_byte(8'h66);
    idle(1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    chk_all_zero("after_abort");
    chk("abort_no_start", 32'(obs_start), 32'(exp_start));
    chk("abort_no_to", 32'(obs_to), 32'(exp_to));
    run_cmd(8'h0A, 8'h0B, 8'h01, 0, 1, 0);
    chk("after_abort_tx", 32'(bus_if.o_tx_data), 32'hFF);

    // Randomized commands.
    for (int i = 0; i < 15; i++) begin
      run_cmd(8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 2));
    end

    idle(3);
    chk("total_starts", 32'(obs_start), 32'(exp_start));
    chk("total_timeouts", 32'(obs_to), 32'(exp_to));
    chk("total_overruns", 32'(obs_ovr), 32'(exp_ovr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
